uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter among N_REQ byte-stream requesters, such as a command responder, a status reporter and a debug tap. Each requester gets its grant for a whole multi-byte packet, which ends at req_last, so packets from different requesters never interleave on the line. The block sits between the requesters and the existing UART TX datapath. It sequences that datapath through a tx_start / tx_busy handshake.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbitration slice.
// Consumed by uart_rr_pick and uart_tx_arbiter.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } arb_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from ptr.
// Returns a one-hot pick, its index and an any-valid flag.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        int j;
        j    = 0;
        pick = '0;
        idx  = '0;
        any  = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[IW'(j)]) begin
                pick         = '0;
                pick[IW'(j)] = 1'b1;
                idx          = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter.
// Optional stall timeout in LOAD enabled by `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          N_REQ          = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]       tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic                    arb_timeout
);

    localparam int IW = clog2_min1(N_REQ);

    arb_state_t state, state_nxt;

    logic [N_REQ-1:0]  grant_q;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     ptr_inc;
    logic              last_q;
    logic [BYTE_W-1:0] data_q;

    logic [N_REQ-1:0]  pick;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic              valid_g;
    logic              last_g;
    logic [BYTE_W-1:0] data_g;
    logic              accept;
    logic              timeout;
    logic              release_pkt;

    uart_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        valid_g = 1'b0;
        last_g  = 1'b0;
        data_g  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx == IW'(i)) begin
                valid_g = req_valid[i];
                last_g  = req_last[i];
                data_g  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign accept  = (state == ST_LOAD) && valid_g && !tx_busy;
    assign ptr_inc = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] stall_cnt;

    // Counter is held at zero outside LOAD, so it starts fresh on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state != ST_LOAD) begin
            stall_cnt <= '0;
        end else if (!valid_g) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign timeout = (state == ST_LOAD) && !accept &&
                     (stall_cnt >= TIMEOUT_CYCLES);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign release_pkt = ((state == ST_WAIT_DONE) && !tx_busy && last_q) ||
                         timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    state_nxt = ST_START;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_nxt = last_q ? ST_IDLE : ST_LOAD;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_start    = (state == ST_START);
        req_ready   = accept ? grant_q : '0;
        grant       = grant_q;
        tx_data     = data_q;
        arb_timeout = timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            gidx    <= '0;
            ptr     <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            if ((state == ST_IDLE) && pick_any) begin
                grant_q <= pick;
                gidx    <= pick_idx;
            end
            if (accept) begin
                data_q <= data_g;
                last_q <= last_g;
            end
            if (release_pkt) begin
                grant_q <= '0;
                ptr     <= ptr_inc;
            end
        end
    end

endmodule
